// File: rtl/ahb_resp_mux_if.sv
// AHB response-mux bus bundle: address-phase decode inputs, per-slave responses
// and the muxed response returned to the master (slave modport = the mux itself).
interface ahb_resp_mux_if #(
    parameter int AHB_DATA_WIDTH = 32,
    parameter int SLAVE_DEVICES  = 4
);
    localparam int SEL_WIDTH = $clog2(SLAVE_DEVICES + 1);

    logic [SEL_WIDTH-1:0]                    decoder_sel_in;
    logic [1:0]                              master_trans_in;
    logic [SLAVE_DEVICES-1:0]                slave_readyout_in;
    logic [SLAVE_DEVICES-1:0]                slave_resp_in;
    logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_rdata_in;
    logic                                    master_ready_out;
    logic                                    master_resp_out;
    logic [AHB_DATA_WIDTH-1:0]               master_rdata_out;

    modport slave (
        input  decoder_sel_in, master_trans_in,
        input  slave_readyout_in, slave_resp_in, slave_rdata_in,
        output master_ready_out, master_resp_out, master_rdata_out
    );

    modport master (
        output decoder_sel_in, master_trans_in,
        output slave_readyout_in, slave_resp_in, slave_rdata_in,
        input  master_ready_out, master_resp_out, master_rdata_out
    );
endinterface

// File: rtl/ahb_resp_mux.sv
// AHB-Lite response multiplexer with built-in default slave (two-cycle ERROR).
// Optional stall timeout enabled by defining AHB_RESP_MUX_TIMEOUT_EN.
module ahb_resp_mux #(
    parameter int AHB_DATA_WIDTH = 32,
    parameter int SLAVE_DEVICES  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          bus_clk_in,
    input  logic          bus_rstn_in,
    ahb_resp_mux_if.slave bus,
    output logic          timeout_flag_out
);
    localparam int SEL_WIDTH = $clog2(SLAVE_DEVICES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUTE = 2'd1;
    localparam logic [1:0] ST_ERR1  = 2'd2;
    localparam logic [1:0] ST_ERR2  = 2'd3;

    if (SLAVE_DEVICES < 1 || SLAVE_DEVICES > 15) begin : g_bad_slave_devices
        $error("ahb_resp_mux: SLAVE_DEVICES must be 1..15");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
        $error("ahb_resp_mux: TIMEOUT_CYCLES must be 2..255");
    end

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic [1:0]                addr_next;
    logic [SEL_WIDTH-1:0]      dsel;
    logic                      dact;
    logic                      dsel_legal;
    logic                      timeout_hit;
    logic                      routed_ready;
    logic                      routed_resp;
    logic [AHB_DATA_WIDTH-1:0] routed_rdata;

    // HTRANS[0] only separates BUSY/IDLE and NONSEQ/SEQ, which never affects routing.
    logic unused_trans_lsb;
    assign unused_trans_lsb = bus.master_trans_in[0];

    function automatic logic sel_legal(input logic [SEL_WIDTH-1:0] sel);
        return (sel != '0) && (int'(sel) <= SLAVE_DEVICES);
    endfunction

    assign dsel_legal = sel_legal(dsel);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        routed_ready = 1'b1;
        routed_resp  = 1'b0;
        routed_rdata = '0;
        for (int k = 0; k < SLAVE_DEVICES; k++) begin
            if (int'(dsel) == k + 1) begin
                routed_ready = bus.slave_readyout_in[k];
                routed_resp  = bus.slave_resp_in[k];
                routed_rdata = bus.slave_rdata_in[k*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        bus.master_ready_out = 1'b1;
        bus.master_resp_out  = 1'b0;
        bus.master_rdata_out = '0;
        case (state)
            ST_ROUTE: begin
                if (dact && dsel_legal) begin
                    bus.master_ready_out = routed_ready;
                    bus.master_resp_out  = routed_resp;
                    bus.master_rdata_out = routed_rdata;
                end
            end
            ST_ERR1: begin
                bus.master_ready_out = 1'b0;
                bus.master_resp_out  = 1'b1;
            end
            ST_ERR2: bus.master_resp_out = 1'b1;
            default: ;
        endcase
    end

    // Address-phase decision; only taken on edges where the current data phase completes.
    always_comb begin
        if (!bus.master_trans_in[1])
            addr_next = ST_IDLE;
        else if (sel_legal(bus.decoder_sel_in))
            addr_next = ST_ROUTE;
        else
            addr_next = ST_ERR1;

        state_nxt = addr_next;
        case (state)
            ST_ROUTE: begin
                if (!bus.master_ready_out)
                    state_nxt = timeout_hit ? ST_ERR1 : ST_ROUTE;
            end
            ST_ERR1:  state_nxt = ST_ERR2;
            default:  ;
        endcase
    end

    always_ff @(posedge bus_clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!bus_rstn_in) begin
            state <= ST_IDLE;
            dsel  <= '0;
            dact  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.master_ready_out) begin
                dsel <= bus.decoder_sel_in;
                dact <= bus.master_trans_in[1];
            end
        end
    end

`ifdef AHB_RESP_MUX_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] stall_cnt;
    logic       stalled;

    assign stalled     = (state == ST_ROUTE) && !bus.master_ready_out;
    assign timeout_hit = stalled && (stall_cnt == STALL_LAST);

    always_ff @(posedge bus_clk_in) begin
        if (!bus_rstn_in) begin
            stall_cnt        <= '0;
            timeout_flag_out <= 1'b0;
        end else begin
            if (stalled && !timeout_hit)
                stall_cnt <= stall_cnt + 8'd1;
            else
                stall_cnt <= '0;
            if (timeout_hit)
                timeout_flag_out <= 1'b1;
        end
    end
`else
    assign timeout_hit      = 1'b0;
    assign timeout_flag_out = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed self-checking bench for ahb_resp_mux (4 slaves, 32-bit data, timeout 4).
module tb_ahb_resp_mux;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 4;

    localparam logic [33:0] IDLE_O = {1'b1, 1'b0, 32'h0};
    localparam logic [33:0] ERR1_O = {1'b0, 1'b1, 32'h0};
    localparam logic [33:0] ERR2_O = {1'b1, 1'b1, 32'h0};

    logic bus_clk_in  = 1'b0;
    logic bus_rstn_in = 1'b0;
    logic timeout_flag_out;
    int   checks = 0;
    int   errors = 0;
    logic [33:0] exp_v;

    ahb_resp_mux_if #(.AHB_DATA_WIDTH(W), .SLAVE_DEVICES(N)) bus ();

    ahb_resp_mux #(
        .AHB_DATA_WIDTH(W),
        .SLAVE_DEVICES (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .bus_clk_in      (bus_clk_in),
        .bus_rstn_in     (bus_rstn_in),
        .bus             (bus.slave),
        .timeout_flag_out(timeout_flag_out)
    );

    always #5 bus_clk_in = ~bus_clk_in;

    function automatic logic [31:0] sd(input int k);
        return 32'hA5A5_0000 + 32'(k);
    endfunction

    function automatic logic [33:0] obs();
        return {bus.master_ready_out, bus.master_resp_out, bus.master_rdata_out};
    endfunction

    task automatic next_cycle();
        @(posedge bus_clk_in);
        #1;
    endtask

    task automatic addr(input logic [1:0] t, input logic [2:0] s);
        bus.master_trans_in = t;
        bus.decoder_sel_in  = s;
    endtask

    task automatic test_reset();
        bus_rstn_in = 1'b0;
        addr(2'b10, 3'd2);
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (obs() !== IDLE_O) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs(), IDLE_O);
        end
        checks++;
        if (timeout_flag_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_flag: got %b expected 0", timeout_flag_out);
        end
        bus_rstn_in = 1'b1;
        addr(2'b00, 3'd0);
        next_cycle();
        #1;
        checks++;
        if (obs() !== IDLE_O) begin
            errors++;
            $display("FAIL reset_release_idle: got %h expected %h", obs(), IDLE_O);
        end
        next_cycle();
    endtask

    task automatic test_legal();
        addr(2'b10, 3'd2);
        #1;
        checks++;
        if (obs() !== IDLE_O) begin
            errors++;
            $display("FAIL legal_addr_phase: got %h expected %h", obs(), IDLE_O);
        end
        next_cycle();
        addr(2'b00, 3'd0);
        #1;
        exp_v = {1'b1, 1'b0, 32'hA5A5_0001};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL legal_data_phase: got %h expected %h", obs(), exp_v);
        end
        next_cycle();
        #1;
        checks++;
        if (obs() !== IDLE_O) begin
            errors++;
            $display("FAIL legal_return_idle: got %h expected %h", obs(), IDLE_O);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= N; i++) begin
            if (i < N) addr((i == 0) ? 2'b10 : 2'b11, 3'(i + 1));
            else       addr(2'b00, 3'd0);
            #1;
            exp_v = (i == 0) ? IDLE_O : {1'b1, 1'b0, sd(i - 1)};
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL b2b_slot%0d: got %h expected %h", i, obs(), exp_v);
            end
            next_cycle();
        end
    endtask

    task automatic test_default_slave();
        logic [2:0] bad_sel [3];
        bad_sel = '{3'd0, 3'd5, 3'd7};
        for (int i = 0; i < 3; i++) begin
            addr(2'b10, bad_sel[i]);
            next_cycle();
            addr(2'b10, 3'd2);
            #1;
            checks++;
            if (obs() !== ERR1_O) begin
                errors++;
                $display("FAIL dflt_err1_sel%0d: got %h expected %h", bad_sel[i], obs(), ERR1_O);
            end
            next_cycle();
            addr(2'b00, 3'd0);
            #1;
            checks++;
            if (obs() !== ERR2_O) begin
                errors++;
                $display("FAIL dflt_err2_sel%0d: got %h expected %h", bad_sel[i], obs(), ERR2_O);
            end
            next_cycle();
            #1;
            checks++;
            if (obs() !== IDLE_O) begin
                errors++;
                $display("FAIL dflt_idle_sel%0d: got %h expected %h", bad_sel[i], obs(), IDLE_O);
            end
            next_cycle();
        end
    endtask

    task automatic test_err_then_route();
        addr(2'b10, 3'd0);
        next_cycle();
        addr(2'b10, 3'd0);
        next_cycle();
        addr(2'b10, 3'd3);
        #1;
        checks++;
        if (obs() !== ERR2_O) begin
            errors++;
            $display("FAIL err2_addr_phase: got %h expected %h", obs(), ERR2_O);
        end
        next_cycle();
        addr(2'b00, 3'd0);
        #1;
        exp_v = {1'b1, 1'b0, sd(2)};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL err2_then_route: got %h expected %h", obs(), exp_v);
        end
        next_cycle();
    endtask

    task automatic test_wait_states();
        int junk_sel [3];
        junk_sel = '{2, 0, 3};
        addr(2'b10, 3'd4);
        next_cycle();
        bus.slave_readyout_in[3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr(2'b10, 3'(junk_sel[i]));
            #1;
            exp_v = {1'b0, 1'b0, sd(3)};
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL wait_cycle%0d: got %h expected %h", i, obs(), exp_v);
            end
            next_cycle();
        end
        bus.slave_readyout_in[3] = 1'b1;
        addr(2'b10, 3'd1);
        #1;
        exp_v = {1'b1, 1'b0, sd(3)};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL wait_complete: got %h expected %h", obs(), exp_v);
        end
        next_cycle();
        addr(2'b00, 3'd0);
        #1;
        exp_v = {1'b1, 1'b0, sd(0)};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL wait_next_slave: got %h expected %h", obs(), exp_v);
        end
        next_cycle();
    endtask

    task automatic test_slave_error();
        addr(2'b10, 3'd1);
        next_cycle();
        bus.slave_readyout_in[0] = 1'b0;
        bus.slave_resp_in[0]     = 1'b1;
        addr(2'b10, 3'd2);
        #1;
        exp_v = {1'b0, 1'b1, sd(0)};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL slv_err_first: got %h expected %h", obs(), exp_v);
        end
        next_cycle();
        bus.slave_readyout_in[0] = 1'b1;
        addr(2'b00, 3'd0);
        #1;
        exp_v = {1'b1, 1'b1, sd(0)};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL slv_err_second: got %h expected %h", obs(), exp_v);
        end
        next_cycle();
        bus.slave_resp_in[0] = 1'b0;
        #1;
        checks++;
        if (obs() !== IDLE_O) begin
            errors++;
            $display("FAIL slv_err_idle: got %h expected %h", obs(), IDLE_O);
        end
        next_cycle();
    endtask

    task automatic test_stall();
        addr(2'b10, 3'd1);
        next_cycle();
        bus.slave_readyout_in[0] = 1'b0;
        addr(2'b00, 3'd0);
`ifdef AHB_RESP_MUX_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            #1;
            exp_v = {1'b0, 1'b0, sd(0)};
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL timeout_wait%0d: got %h expected %h", i, obs(), exp_v);
            end
            next_cycle();
        end
        #1;
        checks++;
        if (obs() !== ERR1_O) begin
            errors++;
            $display("FAIL timeout_err1: got %h expected %h", obs(), ERR1_O);
        end
        checks++;
        if (timeout_flag_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag_set: got %b expected 1", timeout_flag_out);
        end
        next_cycle();
        #1;
        checks++;
        if (obs() !== ERR2_O) begin
            errors++;
            $display("FAIL timeout_err2: got %h expected %h", obs(), ERR2_O);
        end
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (timeout_flag_out !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag_sticky: got %b expected 1", timeout_flag_out);
        end
        bus.slave_readyout_in[0] = 1'b1;
        bus_rstn_in = 1'b0;
        next_cycle();
        bus_rstn_in = 1'b1;
        #1;
        checks++;
        if (timeout_flag_out !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag_reset: got %b expected 0", timeout_flag_out);
        end
        next_cycle();
`else
        for (int i = 0; i < 20; i++) begin
            #1;
            exp_v = {1'b0, 1'b0, sd(0)};
            checks++;
            if ({obs(), timeout_flag_out} !== {exp_v, 1'b0}) begin
                errors++;
                $display("FAIL stall_wait%0d: got %h/%b expected %h/0", i, obs(), timeout_flag_out, exp_v);
            end
            next_cycle();
        end
        bus.slave_readyout_in[0] = 1'b1;
        #1;
        exp_v = {1'b1, 1'b0, sd(0)};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL stall_release: got %h expected %h", obs(), exp_v);
        end
        next_cycle();
        #1;
        checks++;
        if (obs() !== IDLE_O) begin
            errors++;
            $display("FAIL stall_idle: got %h expected %h", obs(), IDLE_O);
        end
        next_cycle();
`endif
    endtask

    task automatic test_reset_abort();
        addr(2'b10, 3'd0);
        next_cycle();
        addr(2'b00, 3'd0);
        bus_rstn_in = 1'b0;
        #1;
        checks++;
        if (obs() !== ERR1_O) begin
            errors++;
            $display("FAIL rst_sync_err1: got %h expected %h", obs(), ERR1_O);
        end
        next_cycle();
        #1;
        checks++;
        if (obs() !== IDLE_O) begin
            errors++;
            $display("FAIL rst_abort_err1: got %h expected %h", obs(), IDLE_O);
        end
        bus_rstn_in = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (obs() !== IDLE_O) begin
            errors++;
            $display("FAIL rst_no_err2: got %h expected %h", obs(), IDLE_O);
        end
        next_cycle();
        addr(2'b10, 3'd2);
        next_cycle();
        bus.slave_readyout_in[1] = 1'b0;
        addr(2'b00, 3'd0);
        bus_rstn_in = 1'b0;
        #1;
        exp_v = {1'b0, 1'b0, sd(1)};
        checks++;
        if (obs() !== exp_v) begin
            errors++;
            $display("FAIL rst_sync_route: got %h expected %h", obs(), exp_v);
        end
        next_cycle();
        #1;
        checks++;
        if (obs() !== IDLE_O) begin
            errors++;
            $display("FAIL rst_abort_route: got %h expected %h", obs(), IDLE_O);
        end
        bus_rstn_in = 1'b1;
        bus.slave_readyout_in[1] = 1'b1;
        next_cycle();
    endtask

    initial begin
        bus.slave_readyout_in = '1;
        bus.slave_resp_in     = '0;
        for (int k = 0; k < N; k++) bus.slave_rdata_in[k*W +: W] = sd(k);
        addr(2'b00, 3'd0);
        #1;
        test_reset();
        test_legal();
        test_back_to_back();
        test_default_slave();
        test_err_then_route();
        test_wait_states();
        test_slave_error();
        test_stall();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- AHB_DATA_WIDTH, 32, read-data width.
- SLAVE_DEVICES, 4, number of slave ports, legal range 1..15.
- TIMEOUT_CYCLES, 16, stall limit in cycles, legal range 2..255.
- SEL_WIDTH, $clog2(SLAVE_DEVICES+1), select width (derived localparam).

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- bus_clk_in, in, 1, single clock; one clock; reset is synchronous and active-low.
- bus_rstn_in, in, 1, synchronous active-low reset.
- decoder_sel_in, in, SEL_WIDTH, address-phase slave index; 1..SLAVE_DEVICES selects slave k-1; 0 or >SLAVE_DEVICES selects the default slave.
- master_trans_in, in, 2, address-phase HTRANS.
- slave_readyout_in, in, SLAVE_DEVICES, per-slave HREADYOUT.
- slave_resp_in, in, SLAVE_DEVICES, per-slave HRESP (1 = ERROR).
- slave_rdata_in, in, SLAVE_DEVICES*AHB_DATA_WIDTH, slave k occupies bits [k*W +: W].
- master_ready_out, out, 1, HREADY to master and slaves.
- master_resp_out, out, 1, HRESP to master.
- master_rdata_out, out, AHB_DATA_WIDTH, HRDATA to master.
- timeout_flag_out, out, 1, sticky stall-timeout indicator.

Function
REQ-003 On a bus_clk_in edge with master_ready_out=1, the block SHALL capture decoder_sel_in into dsel and master_trans_in[1] into dact; while master_ready_out=0 it SHALL hold both.
REQ-004 The FSM SHALL have four states: IDLE, ROUTE, ERR1, ERR2.
REQ-005 On each edge with master_ready_out=1, next state SHALL be:
- IDLE if master_trans_in[1]=0 (IDLE/BUSY);
- ROUTE if master_trans_in[1]=1 and the select is legal;
- ERR1 if master_trans_in[1]=1 and the select is illegal.
REQ-006 In IDLE, outputs SHALL be ready=1, resp=0, rdata=0 (zero-wait OKAY).
REQ-007 In ROUTE, outputs SHALL be combinational from slave dsel-1: ready, resp and the rdata slice.
REQ-008 ROUTE SHALL stay in ROUTE while the routed readyout=0, and SHALL follow REQ-005 when it is 1.
REQ-009 Slave two-cycle ERROR responses SHALL pass through unmodified in ROUTE.
REQ-010 ERR1 SHALL output ready=0, resp=1, rdata=0, and SHALL always go to ERR2 on the next edge.
REQ-011 ERR2 SHALL output ready=1, resp=1, rdata=0, and SHALL follow REQ-005 on the next edge.
REQ-012 Latency: a legal transfer's data phase SHALL begin the cycle after its address phase with no added wait states; a default-slave transfer SHALL take exactly 2 data cycles.
REQ-013 Back-to-back transfers to different slaves SHALL switch routing on the same edge that completes the previous data phase.
REQ-014 master_trans_in and decoder_sel_in SHALL be ignored when master_ready_out=0.

Reset
REQ-015 On an edge with bus_rstn_in=0, the block SHALL set state=IDLE, dsel=0, dact=0, stall counter=0, timeout_flag_out=0, giving master_ready_out=1, master_resp_out=0, master_rdata_out=0.
REQ-016 Reset asserted mid-ROUTE or mid-ERR1/ERR2 SHALL abort the transfer at that edge with no further ERROR cycle.
REQ-017 Reset SHALL have no asynchronous path.

Configuration
REQ-018 Macro AHB_RESP_MUX_TIMEOUT_EN defined:
- An 8-bit counter SHALL increment each ROUTE cycle with routed readyout=0 and clear otherwise.
- When the counter reaches TIMEOUT_CYCLES-1 with readyout still 0, the next state SHALL be ERR1, the counter SHALL clear, and timeout_flag_out SHALL set (sticky until reset).
REQ-019 Macro AHB_RESP_MUX_TIMEOUT_EN undefined: no counter SHALL exist, timeout_flag_out SHALL be tied 0, and ROUTE SHALL wait indefinitely.

Verification
REQ-020 Reset, then NONSEQ to sel=2 with slave1 readyout=1, rdata=0xA5A5_0001 -> next cycle ready=1, resp=0, rdata=0xA5A5_0001.
REQ-021 NONSEQ to sel=0 -> ready/resp = 0/1 then 1/1, rdata=0 both cycles, then IDLE outputs 1/0.
REQ-022 Slave3 readyout=0 for 3 cycles then 1, with a NONSEQ to sel=1 pending -> 3 wait cycles, and dsel changes to 1 only on the completing edge.
REQ-023 Slave0 ERROR (readyout,resp = 0,1 then 1,1) -> identical values on master_ready_out/master_resp_out.
REQ-024 AHB_RESP_MUX_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, slave0 stuck readyout=0 -> 4 wait cycles, then ERR1/ERR2, timeout_flag_out=1 until reset.
REQ-025 bus_rstn_in=0 during ERR1 -> next edge outputs 1/0/0, state IDLE, no ERR2.
